// File: rtl/servo_pwm_bank_if.sv
// Command/status bundle between the angle-decode logic and the servo PWM bank.
// The master drives angle commands and enables; the slave returns pulses and status.
interface servo_pwm_bank_if #(
    parameter int NCH     = 4,
    parameter int ANGLE_W = 8
);
    // angle_wr is a single-cycle strobe with no back-pressure: a write is taken on
    // every clock edge where angle_wr[i] is high, and the last write in a frame wins.
    logic [NCH*ANGLE_W-1:0] angle_in;
    logic [NCH-1:0]         angle_wr;
    logic [NCH-1:0]         enable;
    logic [NCH-1:0]         pwm;
    logic                   period_start;
    logic [NCH-1:0]         busy;

    modport master (
        output angle_in,
        output angle_wr,
        output enable,
        input  pwm,
        input  period_start,
        input  busy
    );

    modport slave (
        input  angle_in,
        input  angle_wr,
        input  enable,
        output pwm,
        output period_start,
        output busy
    );
endinterface

// File: rtl/servo_pwm_bank.sv
// NCH-channel hobby-servo PWM generator on a shared frame counter; each channel
// maps an angle to a pulse width and slews toward it, updating only at frame boundaries.
module servo_pwm_bank #(
    parameter int NCH         = 4,
    parameter int ANGLE_W     = 8,
    parameter int MAX_ANGLE   = 180,
    parameter int PERIOD_CYC  = 480000,
    parameter int MIN_PULSE   = 24000,
    parameter int DEG_CYC     = 133,
    parameter int SLEW        = 1000,
    parameter int RESET_ANGLE = 90
) (
    input  logic             clk,
    input  logic             reset,
    servo_pwm_bank_if.slave  io_bus
);
    localparam int               CNT_W    = $clog2(PERIOD_CYC);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYC - 1);
    localparam logic [CNT_W-1:0] RESET_W  = CNT_W'(MIN_PULSE + RESET_ANGLE * DEG_CYC);
    localparam logic [CNT_W-1:0] MAX_W    = CNT_W'(MIN_PULSE + MAX_ANGLE * DEG_CYC);
    localparam logic [CNT_W-1:0] SLEW_W   = CNT_W'(SLEW);

    logic [CNT_W-1:0] r_cnt;
    logic             r_period_start;
    logic             w_boundary;
    logic [NCH-1:0]   w_pwm;
    logic [NCH-1:0]   w_busy;

    assign w_boundary = (r_cnt == LAST_CNT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_period_start <= (r_cnt == '0);
            r_cnt          <= w_boundary ? '0 : r_cnt + 1'b1;
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [ANGLE_W-1:0] w_angle;
        logic [CNT_W-1:0]   w_wr_width;
        logic [CNT_W-1:0]   w_diff;
        logic               w_up;
        logic [CNT_W-1:0]   w_next_cur;
        logic [CNT_W-1:0]   r_tgt;
        logic [CNT_W-1:0]   r_cur;
        logic               r_en_l;
        logic               r_pwm;

        assign w_angle = io_bus.angle_in[i*ANGLE_W +: ANGLE_W];

        // Product formed in 32 bits; the result is below PERIOD_CYC so it fits CNT_W.
        always_comb begin
            w_wr_width = MAX_W;
            if (int'(w_angle) <= MAX_ANGLE) begin
                w_wr_width = CNT_W'(MIN_PULSE + int'(w_angle) * DEG_CYC);
            end
        end

        always_comb begin
            w_up       = (r_tgt >= r_cur);
            w_diff     = w_up ? (r_tgt - r_cur) : (r_cur - r_tgt);
            w_next_cur = r_tgt;
            if ((SLEW != 0) && (int'(w_diff) > SLEW)) begin
                w_next_cur = w_up ? (r_cur + SLEW_W) : (r_cur - SLEW_W);
            end
        end

        // The slew step reads the pre-edge target, so a write landing on the
        // boundary edge only takes effect at the following boundary.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_tgt  <= RESET_W;
                r_cur  <= RESET_W;
                r_en_l <= 1'b0;
                r_pwm  <= 1'b0;
            end else begin
                r_pwm <= r_en_l && (r_cnt < r_cur);
                if (w_boundary) begin
                    r_en_l <= io_bus.enable[i];
                    r_cur  <= w_next_cur;
                end
                if (io_bus.angle_wr[i]) begin
                    r_tgt <= w_wr_width;
                end
            end
        end

        assign w_pwm[i]  = r_pwm;
        assign w_busy[i] = (r_cur != r_tgt);
    end

    assign io_bus.pwm          = w_pwm;
    assign io_bus.period_start = r_period_start;
    assign io_bus.busy         = w_busy;
endmodule

// File: tb/tb_servo_pwm_bank.sv
// Frame-level check of servo_pwm_bank: a slewing and a snapping instance share
// the same stimulus and are measured against a per-frame pulse-width model.
module tb_servo_pwm_bank;
    localparam int NCH         = 4;
    localparam int ANGLE_W     = 8;
    localparam int MAX_ANGLE   = 180;
    localparam int PERIOD_CYC  = 1500;
    localparam int MIN_PULSE   = 200;
    localparam int DEG_CYC     = 5;
    localparam int SLEW_A      = 100;
    localparam int RESET_ANGLE = 90;
    localparam int CNT_W       = $clog2(PERIOD_CYC);
    localparam int NDUT        = 2;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [NCH*ANGLE_W-1:0] angle_in = '0;
    logic [NCH-1:0]         angle_wr = '0;
    logic [NCH-1:0]         enable   = '0;

    servo_pwm_bank_if #(.NCH(NCH), .ANGLE_W(ANGLE_W)) bus_a ();
    servo_pwm_bank_if #(.NCH(NCH), .ANGLE_W(ANGLE_W)) bus_b ();

    assign bus_a.angle_in = angle_in;
    assign bus_a.angle_wr = angle_wr;
    assign bus_a.enable   = enable;
    assign bus_b.angle_in = angle_in;
    assign bus_b.angle_wr = angle_wr;
    assign bus_b.enable   = enable;

    servo_pwm_bank #(
        .NCH(NCH), .ANGLE_W(ANGLE_W), .MAX_ANGLE(MAX_ANGLE), .PERIOD_CYC(PERIOD_CYC),
        .MIN_PULSE(MIN_PULSE), .DEG_CYC(DEG_CYC), .SLEW(SLEW_A), .RESET_ANGLE(RESET_ANGLE)
    ) dut_slew (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus_a)
    );

    servo_pwm_bank #(
        .NCH(NCH), .ANGLE_W(ANGLE_W), .MAX_ANGLE(MAX_ANGLE), .PERIOD_CYC(PERIOD_CYC),
        .MIN_PULSE(MIN_PULSE), .DEG_CYC(DEG_CYC), .SLEW(0), .RESET_ANGLE(RESET_ANGLE)
    ) dut_snap (
        .clk    (clk),
        .reset  (reset),
        .io_bus (bus_b)
    );

    logic [NCH-1:0] pwm_o  [NDUT];
    logic [NCH-1:0] busy_o [NDUT];
    logic           ps_o   [NDUT];
    assign pwm_o[0]  = bus_a.pwm;
    assign pwm_o[1]  = bus_b.pwm;
    assign busy_o[0] = bus_a.busy;
    assign busy_o[1] = bus_b.busy;
    assign ps_o[0]   = bus_a.period_start;
    assign ps_o[1]   = bus_b.period_start;

    // ---------------- reference model ----------------
    int   m_tgt [NDUT][NCH];
    int   m_cur [NDUT][NCH];
    logic m_en  [NCH];

    function automatic int slew_of(input int d);
        return (d == 0) ? SLEW_A : 0;
    endfunction

    function automatic int ang2w(input int a);
        int c;
        c = (a > MAX_ANGLE) ? MAX_ANGLE : a;
        return MIN_PULSE + c * DEG_CYC;
    endfunction

    function automatic int step(input int cur, input int tgt, input int s);
        int d;
        d = tgt - cur;
        if (s == 0 || (d <= s && d >= -s)) return tgt;
        return (d > 0) ? cur + s : cur - s;
    endfunction

    function automatic logic [NCH*ANGLE_W-1:0] one_ang(input int ch, input int a);
        logic [NCH*ANGLE_W-1:0] v;
        v = '0;
        v[ch*ANGLE_W +: ANGLE_W] = ANGLE_W'(a);
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < NCH; i++) begin
                m_tgt[d][i] = ang2w(RESET_ANGLE);
                m_cur[d][i] = ang2w(RESET_ANGLE);
            end
        end
        for (int i = 0; i < NCH; i++) m_en[i] = 1'b0;
    endtask

    // ---------------- scoreboard ----------------
    logic [CNT_W-1:0] exp_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_async_reset();
        #1 reset = 1'b1;
        angle_wr = '0;
        #1;
        for (int d = 0; d < NDUT; d++) check_val($sformatf("async_pwm_d%0d", d), int'(pwm_o[d]), 0);
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check_val($sformatf("rst_pwm_d%0d", d), int'(pwm_o[d]), 0);
            check_val($sformatf("rst_pstart_d%0d", d), int'(ps_o[d]), 0);
            check_val($sformatf("rst_busy_d%0d", d), int'(busy_o[d]), 0);
        end
        reset = 1'b0;
        model_reset();
    endtask

    // One frame of PERIOD_CYC edges; edge k has cnt == k-1 before it, edge PERIOD_CYC is the boundary.
    task automatic run_frame(input int wr_k, input logic [NCH-1:0] wr_mask,
                             input logic [NCH*ANGLE_W-1:0] wr_ang,
                             input int en_k, input logic [NCH-1:0] en_new, input int rst_k);
        int   hi     [NDUT][NCH];
        int   first  [NDUT][NCH];
        int   ps_cnt [NDUT];
        for (int d = 0; d < NDUT; d++) begin
            ps_cnt[d] = 0;
            for (int i = 0; i < NCH; i++) begin
                hi[d][i]    = 0;
                first[d][i] = 0;
                exp_q.push_back(CNT_W'(m_en[i] ? m_cur[d][i] : 0));
            end
        end
        for (int k = 1; k <= PERIOD_CYC; k++) begin
            angle_in = wr_ang;
            angle_wr = (k == wr_k) ? wr_mask : '0;
            if (k == en_k) enable = en_new;
            @(posedge clk);
            if (k == PERIOD_CYC) begin
                for (int i = 0; i < NCH; i++) m_en[i] = enable[i];
                for (int d = 0; d < NDUT; d++)
                    for (int i = 0; i < NCH; i++)
                        m_cur[d][i] = step(m_cur[d][i], m_tgt[d][i], slew_of(d));
            end
            if (k == wr_k) begin
                for (int i = 0; i < NCH; i++)
                    if (wr_mask[i])
                        for (int d = 0; d < NDUT; d++)
                            m_tgt[d][i] = ang2w(int'(wr_ang[i*ANGLE_W +: ANGLE_W]));
            end
            #1;
            for (int d = 0; d < NDUT; d++) begin
                if (ps_o[d]) ps_cnt[d]++;
                for (int i = 0; i < NCH; i++) begin
                    if (pwm_o[d][i]) hi[d][i]++;
                    if (k == 1) first[d][i] = int'(pwm_o[d][i]);
                end
                if (k == 1) check_val($sformatf("pstart_k1_d%0d", d), int'(ps_o[d]), 1);
                if (k == 1 || k == PERIOD_CYC)
                    for (int i = 0; i < NCH; i++)
                        check_val($sformatf("busy_k%0d_d%0d_ch%0d", k, d, i),
                                  int'(busy_o[d][i]), int'(m_cur[d][i] != m_tgt[d][i]));
            end
            if (k == rst_k) begin
                do_async_reset();
                repeat (NDUT * NCH) void'(exp_q.pop_front());
                return;
            end
        end
        angle_wr = '0;
        for (int d = 0; d < NDUT; d++) begin
            check_val($sformatf("pstart_count_d%0d", d), ps_cnt[d], 1);
            for (int i = 0; i < NCH; i++) begin
                int e;
                e = int'(exp_q.pop_front());
                check_val($sformatf("width_d%0d_ch%0d", d, i), hi[d][i], e);
                check_val($sformatf("pulse_start_d%0d_ch%0d", d, i), first[d][i], int'(e > 0));
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            check_val($sformatf("init_pwm_d%0d", d), int'(pwm_o[d]), 0);
            check_val($sformatf("init_pstart_d%0d", d), int'(ps_o[d]), 0);
            check_val($sformatf("init_busy_d%0d", d), int'(busy_o[d]), 0);
        end
        reset = 1'b0;

        // Default width on ch0 only.
        run_frame(0, '0, '0, 1, 4'b0001, 0);
        run_frame(0, '0, '0, 0, '0, 0);
        run_frame(0, '0, '0, 0, '0, 0);

        // Full-scale write to ch0: slew on one instance, snap on the other.
        run_frame(100, 4'b0001, one_ang(0, 180), 0, '0, 0);
        repeat (5) run_frame(0, '0, '0, 0, '0, 0);

        // Over-range command clamps to MAX_ANGLE.
        run_frame(500, 4'b0010, one_ang(1, 250), 1, 4'b1111, 0);
        run_frame(0, '0, '0, 0, '0, 0);

        // Write landing on the boundary edge.
        run_frame(PERIOD_CYC, 4'b0100, one_ang(2, 0), 0, '0, 0);
        repeat (3) run_frame(0, '0, '0, 0, '0, 0);

        // Drop ch0 enable mid-pulse while its target moves away.
        run_frame(200, 4'b0001, one_ang(0, 0), 50, 4'b1110, 0);
        repeat (3) run_frame(0, '0, '0, 0, '0, 0);
        run_frame(0, '0, '0, 10, 4'b1111, 0);
        repeat (2) run_frame(0, '0, '0, 0, '0, 0);

        // Asynchronous reset in the middle of the pulses.
        run_frame(0, '0, '0, 0, '0, 100);
        run_frame(0, '0, '0, 1, 4'b0001, 0);
        run_frame(0, '0, '0, 0, '0, 0);

        // Randomized frames.
        for (int f = 0; f < 8; f++) begin
            run_frame($urandom_range(1, PERIOD_CYC), 4'($urandom_range(0, 15)), $urandom,
                      $urandom_range(1, PERIOD_CYC), 4'($urandom_range(0, 15)), 0);
        end

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
